// File: rtl/midi_uart_tx_if.sv
// MIDI event handshake: producer holds valid and fields stable until a one-cycle ack.
interface midi_uart_tx_if;
  logic       midi_event_valid;
  logic [7:0] midi_command;
  logic [6:0] midi_parameter_1;
  logic [6:0] midi_parameter_2;
  logic       midi_event_ack;

  modport master (
    output midi_event_valid,
    output midi_command,
    output midi_parameter_1,
    output midi_parameter_2,
    input  midi_event_ack
  );

  modport slave (
    input  midi_event_valid,
    input  midi_command,
    input  midi_parameter_1,
    input  midi_parameter_2,
    output midi_event_ack
  );
endinterface

// File: rtl/midi_uart_tx.sv
// MIDI event serializer: one event per handshake, sent as 8N1 bytes on o_serial_tx.
// Optional running-status compression is enabled by defining MIDI_RUNNING_STATUS_EN.
module midi_uart_tx #(
  parameter int unsigned CLK_FREQ  = 16000000,
  parameter int unsigned BAUD_RATE = 31250
) (
  input  logic           i_clk,
  input  logic           i_rst,
  midi_uart_tx_if.slave  evt,
  output logic           o_serial_tx,
  output logic           o_busy
);

  localparam int unsigned DIV   = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StStart, StData, StStop} state_t;

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [2:0]        r_bit;
  logic [1:0]        r_byte_idx;
  logic [1:0]        r_nbytes;
  logic [2:0][7:0]   r_bytes;
  logic [7:0]        r_shift;
  logic              r_ack;
  logic              r_tx;
  logic              r_busy;

  logic [1:0]        w_len;
  logic              w_chan_voice;
  logic              w_skip;
  logic [1:0]        w_nbytes;
  logic [2:0][7:0]   w_bytes;
  logic              w_capture;

  function automatic logic [1:0] f_len(input logic [7:0] cmd);
    logic [1:0] len;
    len = 2'd1;
    case (cmd[7:4])
      4'h8, 4'h9, 4'hA, 4'hB, 4'hE: len = 2'd3;
      4'hC, 4'hD:                   len = 2'd2;
      4'hF: begin
        case (cmd[3:0])
          4'h1, 4'h3: len = 2'd2;
          4'h2:       len = 2'd3;
          default:    len = 2'd1;
        endcase
      end
      default: len = 2'd0;
    endcase
    return len;
  endfunction

  assign w_len        = f_len(evt.midi_command);
  assign w_chan_voice = evt.midi_command[7] && (evt.midi_command[7:4] != 4'hF);
  assign w_capture    = (r_state == StIdle) && evt.midi_event_valid;

`ifdef MIDI_RUNNING_STATUS_EN
  logic [7:0] r_last_status;

  assign w_skip = w_chan_voice && (evt.midi_command == r_last_status);

  // Realtime (0xF8-0xFF) and invalid status leave the running status untouched.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_last_status <= 8'h00;
    end else if (w_capture && evt.midi_command[7]) begin
      if (w_chan_voice) begin
        r_last_status <= evt.midi_command;
      end else if (!evt.midi_command[3]) begin
        r_last_status <= 8'h00;
      end
    end
  end
`else
  assign w_skip = 1'b0;
`endif

  assign w_nbytes = w_len - {1'b0, w_skip};

  always_comb begin
    w_bytes = '0;
    if (w_skip) begin
      w_bytes[0] = {1'b0, evt.midi_parameter_1};
      w_bytes[1] = {1'b0, evt.midi_parameter_2};
    end else begin
      w_bytes[0] = evt.midi_command;
      w_bytes[1] = {1'b0, evt.midi_parameter_1};
      w_bytes[2] = {1'b0, evt.midi_parameter_2};
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= StIdle;
      r_cnt      <= '0;
      r_bit      <= '0;
      r_byte_idx <= '0;
      r_nbytes   <= '0;
      r_bytes    <= '0;
      r_shift    <= '0;
      r_ack      <= 1'b0;
      r_tx       <= 1'b1;
      r_busy     <= 1'b0;
    end else begin
      r_ack <= 1'b0;
      case (r_state)
        StIdle: begin
          // Invalid status is acked but never leaves IDLE.
          if (w_capture) begin
            r_ack <= 1'b1;
            if (evt.midi_command[7]) begin
              r_state    <= StLoad;
              r_busy     <= 1'b1;
              r_bytes    <= w_bytes;
              r_nbytes   <= w_nbytes;
              r_byte_idx <= '0;
            end
          end
        end
        StLoad: begin
          r_state <= StStart;
          r_tx    <= 1'b0;
          r_cnt   <= '0;
          r_shift <= r_bytes[0];
        end
        StStart: begin
          if (r_cnt == CNT_MAX) begin
            r_cnt   <= '0;
            r_bit   <= '0;
            r_state <= StData;
            r_tx    <= r_shift[0];
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StData: begin
          if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
            if (r_bit == 3'd7) begin
              r_state <= StStop;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 3'd1;
              r_shift <= {1'b0, r_shift[7:1]};
              r_tx    <= r_shift[1];
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        StStop: begin
          if (r_cnt == CNT_MAX) begin
            r_cnt <= '0;
            if (r_byte_idx == r_nbytes - 2'd1) begin
              r_state <= StIdle;
              r_busy  <= 1'b0;
            end else begin
              // Next byte follows immediately; the pending bytes shift down one slot.
              r_byte_idx <= r_byte_idx + 2'd1;
              r_state    <= StStart;
              r_tx       <= 1'b0;
              r_shift    <= r_bytes[1];
              r_bytes    <= {8'h00, r_bytes[2:1]};
            end
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  assign evt.midi_event_ack = r_ack;
  assign o_serial_tx        = r_tx;
  assign o_busy             = r_busy;

endmodule

// File: doc/midi_uart_tx.md
Name: midi_uart_tx

Overview:
- Transmit-side counterpart of the MIDI UART receive/framer path.
- Accepts one framed MIDI event per valid/ack handshake: status byte plus up to two 7-bit data parameters.
- Serializes the event as 8N1 UART bytes at the MIDI baud rate on serial_tx.
- Used for MIDI THRU/echo, sequencer output and controller feedback from the synth top level.

Parameters:
- CLK_FREQ, 16000000: main clock frequency in Hz.
- BAUD_RATE, 31250: serial bit rate. Bit period DIV = CLK_FREQ/BAUD_RATE cycles (512 at defaults, integer division).

Ports:
- clk  input  1  main clock; everything is clocked on its rising edge.
- rst  input  1  synchronous, active-high reset.
- midi_event_valid  input  1  event present. Held, with the fields stable, until ack.
- midi_command  input  8  status byte.
- midi_parameter_1  input  7  first data byte (MSB sent as 0).
- midi_parameter_2  input  7  second data byte (MSB sent as 0).
- midi_event_ack  output  1  one-cycle pulse: event captured.
- serial_tx  output  1  UART line. Idles high.
- busy  output  1  high from capture until the last stop bit ends.

Behaviour:
- Reset values: serial_tx=1, midi_event_ack=0, busy=0, state IDLE, counters 0.
- State machine:
  - IDLE -> LOAD, on a rising edge with midi_event_valid=1. Command and parameters are registered and byte count N is set. On the same edge midi_event_ack<=1 and busy<=1.
  - LOAD -> START (next cycle). midi_event_ack<=0. serial_tx is driven low on this edge, so the start bit begins the cycle after ack.
  - START: DIV cycles low, then DATA.
  - DATA: 8 bits, LSB first, DIV cycles each, then STOP.
  - STOP: DIV cycles high.
  - After STOP: if more bytes remain, go to START with no idle gap; otherwise go to IDLE with busy<=0.
- Event length N from midi_command:
  - 0x80-0xBF and 0xE0-0xEF: 3 bytes (status, p1, p2).
  - 0xC0-0xDF: 2 bytes (status, p1).
  - 0xF1, 0xF3: 2 bytes.
  - 0xF2: 3 bytes.
  - All other 0xF0-0xFF: 1 byte.
- Invalid status: midi_command[7]=0 is acked normally. Nothing is transmitted, busy stays 0, and the block remains in IDLE.
- Message duration is N*10*DIV cycles, measured from the start-bit falling edge to the end of the last stop bit.
- Back-to-back events: the earliest next capture is the first IDLE cycle after the final stop bit. Minimum inter-message gap is 1 clock high (the IDLE cycle), plus the LOAD cycle.
- Valid is ignored while busy. The event is not lost: the producer holds valid until ack.
- Valid must not be sampled twice for one event. The producer drops valid in the cycle after ack; a still-high valid on the IDLE re-entry counts as a new event.
- Bit counter and byte index are explicitly sized. No wrap beyond bit 7 or byte N-1.
- Reset asserted mid-frame: on the next edge serial_tx=1, busy=0, ack=0 and the state returns to IDLE. The partial byte is abandoned. Running status (if enabled) is cleared.

Optional Feature:
- Macro: MIDI_RUNNING_STATUS_EN.
- Defined:
  - The block keeps last_status.
  - A channel-voice status (0x80-0xEF) equal to last_status is not retransmitted, so N is reduced by 1.
  - A channel-voice status that differs is transmitted and updates last_status.
  - 0xF0-0xF7 transmits and clears last_status.
  - 0xF8-0xFF transmits and leaves last_status unchanged.
  - Reset clears last_status.
- Undefined: every message is sent with its status byte, and no last_status register exists.

Test Plan:
- Note-on: valid with 0x90/0x3C/0x64 -> ack is one pulse. serial_tx carries 0x90, 0x3C, 0x64, LSB first, each framed 0/data/1. Total 30*512=15360 cycles. Then busy=0.
- Program change: 0xC5/0x07/0x55 -> only 0xC5, 0x07 sent (20 bit periods). p2 is ignored.
- Realtime and invalid status: 0xF8 -> one byte, 5120 cycles. 0x3C as command -> ack pulse, serial_tx stays high, busy stays 0.
- Back-to-back: valid held high across two events 0x80/0x3C/0x00 then 0xB0/0x01/0x40 -> second ack only after the first final stop bit. The second message's start bit begins within 2 cycles of that.
- Reset mid-byte: rst for 1 cycle at bit 4 of the second byte -> next edge serial_tx=1, busy=0. A new event 0xE0/0x00/0x40 afterwards transmits cleanly.
- MIDI_RUNNING_STATUS_EN: 0x90/0x3C/0x64 then 0x90/0x3E/0x64 -> second message is 2 bytes (0x3E, 0x64). A following 0xF8 is 1 byte. A following 0x90/0x40/0x64 is still 2 bytes. Without the macro, the second message is 3 bytes.
